// File: rtl/apb4_pkg.sv
// Shared types and default widths for the APB4 command sequencer and its FIFO.
package apb4_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned ADDR_WIDTH_DEF = 32;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned STRB_WIDTH_DEF = DATA_WIDTH_DEF / 8;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StSetup,
      StWait
   } state_t;

   typedef struct packed {
      logic                      write;
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [DATA_WIDTH_DEF-1:0] wdata;
      logic [STRB_WIDTH_DEF-1:0] strb;
   } cmd_t;

endpackage

// File: rtl/apb4_sync_fifo.sv
// Synchronous FIFO of command entries; registered level, no fall-through.
module apb4_sync_fifo
   import apb4_pkg::*;
#(
   parameter type         entry_t = cmd_t,
   parameter int unsigned DEPTH   = FIFO_DEPTH_DEF
) (
   input  logic                   PCLK,
   input  logic                   PRESETn,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_LVL = (PTR_W + 1)'(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // full/empty come from the registered level, so a pop never frees room for a same-cycle push
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (level == DEPTH_LVL);
   assign empty    = (level == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop) begin
            level <= level + (PTR_W + 1)'(1);
         end else if (!do_push && do_pop) begin
            level <= level - (PTR_W + 1)'(1);
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/apb4_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to the APB4 bus wrapper,
// returning read data / SLVERR through a valid/ready response port.
module apb4_cmd_sequencer
   import apb4_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                        PCLK,
   input  logic                        PRESETn,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [ADDR_WIDTH-1:0]       cmd_addr,
   input  logic [DATA_WIDTH-1:0]       cmd_wdata,
   input  logic [STRB_WIDTH-1:0]       cmd_strb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_write,
   output logic [DATA_WIDTH-1:0]       rsp_rdata,
   output logic                        rsp_slverr,
   output logic                        TRANSFER,
   output logic                        WRITE,
   output logic [ADDR_WIDTH-1:0]       ADDR,
   output logic [DATA_WIDTH-1:0]       WDATA,
   output logic [STRB_WIDTH-1:0]       STRB,
   input  logic                        READY,
   input  logic [DATA_WIDTH-1:0]       RDATA,
   input  logic                        SLVERR,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy
);

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] strb;
   } seq_cmd_t;

   state_t   state;
   seq_cmd_t push_cmd;
   seq_cmd_t head_cmd;
   logic     fifo_full;
   logic     fifo_empty;
   logic     pop;
   logic     complete;

   assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};

   apb4_sync_fifo #(
      .entry_t (seq_cmd_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .push      (cmd_valid),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign cmd_ready = !fifo_full;
   assign busy      = (state != StIdle);
   // Launch only when the response slot is free (or being freed this cycle)
   assign pop       = (state == StIdle) && !fifo_empty && (!rsp_valid || rsp_ready);
   assign complete  = (state == StWait) && READY;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state      <= StIdle;
         TRANSFER   <= 1'b0;
         WRITE      <= 1'b0;
         ADDR       <= '0;
         WDATA      <= '0;
         STRB       <= '0;
         rsp_valid  <= 1'b0;
         rsp_write  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (pop) begin
                  WRITE    <= head_cmd.write;
                  ADDR     <= head_cmd.addr;
                  WDATA    <= head_cmd.wdata;
                  STRB     <= head_cmd.write ? head_cmd.strb : '0;
                  TRANSFER <= 1'b1;
                  state    <= StLaunch;
               end
            end
            StLaunch: begin
               TRANSFER <= 1'b0;
               state    <= StSetup;
            end
            StSetup: begin
               state <= StWait;
            end
            StWait: begin
               if (READY) state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase

         if (complete) begin
            rsp_valid  <= 1'b1;
            rsp_write  <= WRITE;
            rsp_rdata  <= WRITE ? '0 : RDATA;
            rsp_slverr <= SLVERR;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
         end
      end
   end

endmodule
